reset_sequencer: RTL and testbench

- Controls staged reset release for the display pipeline's subsystems: PLL/clock, then timing generator, then video datapath.
- Waits for a filtered PLL lock, then releases per-stage active-low resets in ascending order with a fixed gap, then signals done.
- Handles runtime re-sequencing: a software reset request drains the stages in reverse order, and PLL lock loss asserts all stages at once.
- Sits directly downstream of the top-level reset synchronizer, in the same clock domain.

---
 rtl/reset_sequencer_if.sv | 43 ++++
 rtl/reset_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_reset_sequencer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/reset_sequencer_if.sv
// -----------------------------------------------------------------------------
// reset_sequencer_if
// Purpose : Groups the lock input, the software request and the sequenced reset
//           status outputs of reset_sequencer into one bundle.
// Signals :
//   pll_locked   - PLL lock, asynchronous to the sequencer clock
//   sw_rst_req   - single-cycle software re-sequence request
//   rst_n_stage  - per-stage active-low resets, bit 0 releases first
//   seq_done     - all stages released and settled
//   busy         - sequencer not in its steady RUN state
//   lock_timeout - sticky lock watchdog flag
// Modports:
//   slave  - the sequencer itself
//   master - the surrounding system (drives lock/request, observes resets)
// -----------------------------------------------------------------------------
interface reset_sequencer_if #(
    parameter int NUM_STAGES = 3
);
    logic                  pll_locked;
    logic                  sw_rst_req;
    logic [NUM_STAGES-1:0] rst_n_stage;
    logic                  seq_done;
    logic                  busy;
    logic                  lock_timeout;

    modport slave (
        input  pll_locked,
        input  sw_rst_req,
        output rst_n_stage,
        output seq_done,
        output busy,
        output lock_timeout
    );

    modport master (
        output pll_locked,
        output sw_rst_req,
        input  rst_n_stage,
        input  seq_done,
        input  busy,
        input  lock_timeout
    );
endinterface

// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
// Purpose : Staged reset release for the display pipeline. Waits for a filtered
//           PLL lock, releases the per-stage active-low resets in ascending
//           order with a fixed gap, then reports done. A software request
//           drains the stages in reverse order; lock loss asserts all at once.
// Ports   :
//   clk         - system clock
//   async_rst_n - asynchronous active-low reset (from the reset synchronizer)
//   seq_if      - reset_sequencer_if.slave (lock, request, stage resets, status)
// Build option:
//   RST_SEQ_WDOG_EN - when defined, a watchdog counts cycles spent in
//                     WAIT_LOCK and sets the sticky lock_timeout flag after
//                     WDOG_CYCLES. When undefined, lock_timeout is tied 0.
//
// state      | meaning
// -----------+------------------------------------------------------------
// WAIT_LOCK  | all stages asserted, qualifying PLL lock through the filter
// RELEASE    | releasing one stage every STAGE_GAP cycles, then settling
// RUN        | all stages released, seq_done high
// DRAIN      | re-asserting stages one per cycle, highest index first
// -----------------------------------------------------------------------------
module reset_sequencer #(
    parameter int NUM_STAGES  = 3,
    parameter int LOCK_FILTER = 16,
    parameter int STAGE_GAP   = 8,
    parameter int WDOG_CYCLES = 65536
) (
    input  logic              clk,
    input  logic              async_rst_n,
    reset_sequencer_if.slave  seq_if
);

    if (NUM_STAGES < 1 || NUM_STAGES > 8 || LOCK_FILTER < 1 ||
        STAGE_GAP < 1 || WDOG_CYCLES < 1) begin : g_bad_param
        $error("reset_sequencer: parameter out of range");
    end

    localparam int FILT_W = $clog2(LOCK_FILTER + 1);
    localparam int GAP_W  = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;

    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILTER - 1);
    localparam logic [FILT_W-1:0] FILT_MAX  = FILT_W'(LOCK_FILTER);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP - 1);

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_RELEASE   = 2'd1,
        ST_RUN       = 2'd2,
        ST_DRAIN     = 2'd3
    } state_t;

    logic                  r_sync1;
    logic                  r_lock_s;
    logic [FILT_W-1:0]     r_filt;
    logic [GAP_W-1:0]      r_gap;
    state_t                r_state;
    logic [NUM_STAGES-1:0] r_stage;
    logic                  r_done;
    logic                  r_busy;

    state_t                w_state_nxt;
    logic [NUM_STAGES-1:0] w_stage_nxt;
    logic                  w_done_nxt;
    logic [GAP_W-1:0]      w_gap_nxt;
    logic                  w_filt_clr;
    logic                  w_lock_ok;
    logic                  w_gap_hit;
    logic                  w_all_rel;
    logic [NUM_STAGES-1:0] w_stage_fill;
    logic [NUM_STAGES-1:0] w_stage_drain;

    // Stage vector is always a thermometer code (bit k set implies all lower
    // bits set), so releasing the next stage is a shift-in of a one and
    // asserting the highest released stage is a plain right shift. The shift
    // also skips already-asserted bits for free.
    assign w_stage_fill  = (r_stage << 1) | NUM_STAGES'(1);
    assign w_stage_drain = r_stage >> 1;
    assign w_all_rel     = r_stage[NUM_STAGES-1];
    assign w_gap_hit     = (r_gap == GAP_LAST);

    // Qualified on the edge where the filter would reach LOCK_FILTER.
    assign w_lock_ok     = r_lock_s && (r_filt >= FILT_LAST);

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            r_sync1  <= 1'b0;
            r_lock_s <= 1'b0;
        end else begin
            r_sync1  <= seq_if.pll_locked;
            r_lock_s <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            r_filt <= '0;
        end else if (!r_lock_s || w_filt_clr) begin
            r_filt <= '0;
        end else if (r_filt != FILT_MAX) begin
            r_filt <= r_filt + FILT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            r_state <= ST_WAIT_LOCK;
            r_stage <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b1;
            r_gap   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_stage <= w_stage_nxt;
            r_done  <= w_done_nxt;
            r_busy  <= (w_state_nxt != ST_RUN);
            r_gap   <= w_gap_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_stage_nxt = r_stage;
        w_done_nxt  = r_done;
        w_gap_nxt   = r_gap;
        w_filt_clr  = 1'b0;

        unique case (r_state)
            ST_WAIT_LOCK: begin
                w_stage_nxt = '0;
                w_done_nxt  = 1'b0;
                if (w_lock_ok) begin
                    w_state_nxt = ST_RELEASE;
                    w_stage_nxt = NUM_STAGES'(1);
                    w_gap_nxt   = '0;
                end
            end

            ST_RELEASE: begin
                if (!r_lock_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_stage_nxt = '0;
                    w_done_nxt  = 1'b0;
                end else if (seq_if.sw_rst_req) begin
                    w_state_nxt = ST_DRAIN;
                    w_done_nxt  = 1'b0;
                end else if (w_gap_hit) begin
                    w_gap_nxt = '0;
                    // The gap after the last stage is the settle time.
                    if (w_all_rel) begin
                        w_state_nxt = ST_RUN;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_stage_nxt = w_stage_fill;
                    end
                end else begin
                    w_gap_nxt = r_gap + GAP_W'(1);
                end
            end

            ST_RUN: begin
                if (!r_lock_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_stage_nxt = '0;
                    w_done_nxt  = 1'b0;
                end else if (seq_if.sw_rst_req) begin
                    w_state_nxt = ST_DRAIN;
                    w_done_nxt  = 1'b0;
                end
            end

            ST_DRAIN: begin
                w_done_nxt = 1'b0;
                if (!r_lock_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_stage_nxt = '0;
                end else begin
                    w_stage_nxt = w_stage_drain;
                    // Bit 0 goes down now: lock has to be re-qualified.
                    if (w_stage_drain == '0) begin
                        w_state_nxt = ST_WAIT_LOCK;
                        w_filt_clr  = 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_WAIT_LOCK;
                w_stage_nxt = '0;
                w_done_nxt  = 1'b0;
            end
        endcase
    end

`ifdef RST_SEQ_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(WDOG_CYCLES);

    logic [WD_W-1:0] r_wdog;
    logic            r_timeout;

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else if (r_state != ST_WAIT_LOCK) begin
            r_wdog <= '0;
        end else begin
            if (r_wdog != WD_MAX) begin
                r_wdog <= r_wdog + WD_W'(1);
            end
            if (r_wdog == WD_LAST) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign seq_if.lock_timeout = r_timeout;
`else
    assign seq_if.lock_timeout = 1'b0;
`endif

    assign seq_if.rst_n_stage = r_stage;
    assign seq_if.seq_done    = r_done;
    assign seq_if.busy        = r_busy;

endmodule

// File: tb/tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer
// Scoreboard bench for reset_sequencer (NUM_STAGES=3, LOCK_FILTER=4,
// STAGE_GAP=2, WDOG_CYCLES=32). Each scenario pushes the expected per-edge
// outputs, drives its stimulus, and the expectations are popped and compared
// as the corresponding edges occur. Edge 1 is the first rising edge after
// async_rst_n is released. Honours RST_SEQ_WDOG_EN for lock_timeout.
// -----------------------------------------------------------------------------
module tb_reset_sequencer;

    localparam int NS  = 3;
    localparam int LF  = 4;
    localparam int GAP = 2;
    localparam int WD  = 32;

`ifdef RST_SEQ_WDOG_EN
    localparam logic WD_ON = 1'b1;
`else
    localparam logic WD_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic async_rst_n = 1'b0;

    reset_sequencer_if #(.NUM_STAGES(NS)) u_if ();

    reset_sequencer #(
        .NUM_STAGES  (NS),
        .LOCK_FILTER (LF),
        .STAGE_GAP   (GAP),
        .WDOG_CYCLES (WD)
    ) u_dut (
        .clk         (clk),
        .async_rst_n (async_rst_n),
        .seq_if      (u_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            edge_no;
        logic [NS-1:0] stage;
        logic          done;
        logic          busy;
        logic          to;
    } exp_t;

    exp_t  sb_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    edge_n   = 0;
    string scen     = "init";

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input int e0, input int e1, input logic [NS-1:0] st,
                           input logic dn, input logic bz, input logic to);
        exp_t x;
        for (int e = e0; e <= e1; e++) begin
            x.edge_no = e;
            x.stage   = st;
            x.done    = dn;
            x.busy    = bz;
            x.to      = to;
            sb_q.push_back(x);
        end
    endtask

    task automatic tick();
        exp_t  x;
        string t;
        @(posedge clk);
        #1;
        edge_n++;
        while (sb_q.size() > 0 && sb_q[0].edge_no == edge_n) begin
            x = sb_q.pop_front();
            t = $sformatf("%s_e%0d", scen, x.edge_no);
            check_val({t, "_stage"}, 32'(u_if.rst_n_stage), 32'(x.stage));
            check_val({t, "_done"},  32'(u_if.seq_done),    32'(x.done));
            check_val({t, "_busy"},  32'(u_if.busy),        32'(x.busy));
            check_val({t, "_to"},    32'(u_if.lock_timeout), 32'(x.to));
        end
    endtask

    task automatic run_to(input int last);
        while (edge_n < last) tick();
    endtask

    task automatic sb_drained();
        check_val({scen, "_sb_left"}, 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    // Asserts reset mid-cycle, checks the immediate reset values, then
    // releases it just after an edge so the next edge is edge 1.
    task automatic do_reset(input logic lock);
        @(posedge clk);
        #2;
        async_rst_n       = 1'b0;
        u_if.sw_rst_req   = 1'b0;
        u_if.pll_locked   = lock;
        #1;
        check_val({scen, "_rst_stage"}, 32'(u_if.rst_n_stage), 32'd0);
        check_val({scen, "_rst_done"},  32'(u_if.seq_done),     32'd0);
        check_val({scen, "_rst_busy"},  32'(u_if.busy),         32'd1);
        check_val({scen, "_rst_to"},    32'(u_if.lock_timeout), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        async_rst_n = 1'b1;
        edge_n      = 0;
    endtask

    // Standard power-up expectation with lock held high from reset release.
    task automatic push_powerup(input int run_last);
        sb_push(1, 5,         3'b000, 1'b0, 1'b1, 1'b0);
        sb_push(6, 7,         3'b001, 1'b0, 1'b1, 1'b0);
        sb_push(8, 9,         3'b011, 1'b0, 1'b1, 1'b0);
        sb_push(10, 11,       3'b111, 1'b0, 1'b1, 1'b0);
        sb_push(12, run_last, 3'b111, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        u_if.pll_locked = 1'b0;
        u_if.sw_rst_req = 1'b0;

        // Power-up with lock held high.
        scen = "pwr";
        do_reset(1'b1);
        push_powerup(13);
        run_to(13);
        sb_drained();

        // Software reset from RUN, drain, then full re-sequence. A request
        // seen in WAIT_LOCK must not disturb the re-qualification.
        scen = "swrst";
        sb_push(14, 14, 3'b111, 1'b0, 1'b1, 1'b0);
        sb_push(15, 15, 3'b011, 1'b0, 1'b1, 1'b0);
        sb_push(16, 16, 3'b001, 1'b0, 1'b1, 1'b0);
        sb_push(17, 20, 3'b000, 1'b0, 1'b1, 1'b0);
        sb_push(21, 22, 3'b001, 1'b0, 1'b1, 1'b0);
        sb_push(23, 24, 3'b011, 1'b0, 1'b1, 1'b0);
        sb_push(25, 26, 3'b111, 1'b0, 1'b1, 1'b0);
        sb_push(27, 28, 3'b111, 1'b1, 1'b0, 1'b0);
        u_if.sw_rst_req = 1'b1;
        run_to(14);
        u_if.sw_rst_req = 1'b0;
        run_to(18);
        u_if.sw_rst_req = 1'b1;
        run_to(19);
        u_if.sw_rst_req = 1'b0;
        run_to(28);
        sb_drained();

        // Lock glitch during filtering: lock_s low on edge 5, high again
        // from edge 6, so stage 0 waits until edge 10.
        scen = "glitch";
        do_reset(1'b1);
        sb_push(1, 9,   3'b000, 1'b0, 1'b1, 1'b0);
        sb_push(10, 10, 3'b001, 1'b0, 1'b1, 1'b0);
        run_to(3);
        u_if.pll_locked = 1'b0;
        run_to(4);
        u_if.pll_locked = 1'b1;
        run_to(10);
        sb_drained();

        // Lock loss while stages are 3'b011; stage 2 must never rise.
        // Lock comes back and is re-qualified.
        scen = "lossrel";
        do_reset(1'b1);
        sb_push(1, 5,   3'b000, 1'b0, 1'b1, 1'b0);
        sb_push(6, 7,   3'b001, 1'b0, 1'b1, 1'b0);
        sb_push(8, 9,   3'b011, 1'b0, 1'b1, 1'b0);
        sb_push(10, 19, 3'b000, 1'b0, 1'b1, 1'b0);
        sb_push(20, 20, 3'b001, 1'b0, 1'b1, 1'b0);
        run_to(7);
        u_if.pll_locked = 1'b0;
        run_to(14);
        u_if.pll_locked = 1'b1;
        run_to(20);
        sb_drained();

        // Lock loss and software request seen on the same edge in RUN:
        // everything asserts at once, no drain ordering.
        scen = "simul";
        do_reset(1'b1);
        push_powerup(15);
        sb_push(16, 18, 3'b000, 1'b0, 1'b1, 1'b0);
        run_to(13);
        u_if.pll_locked = 1'b0;
        run_to(15);
        u_if.sw_rst_req = 1'b1;
        run_to(16);
        u_if.sw_rst_req = 1'b0;
        run_to(18);
        sb_drained();

        // Lock absent for 40 cycles: watchdog flag (when built in) from
        // edge 32, sticky through the later full sequence.
        scen = "wdog";
        do_reset(1'b0);
        sb_push(1, 31,  3'b000, 1'b0, 1'b1, 1'b0);
        sb_push(32, 45, 3'b000, 1'b0, 1'b1, WD_ON);
        sb_push(46, 47, 3'b001, 1'b0, 1'b1, WD_ON);
        sb_push(48, 49, 3'b011, 1'b0, 1'b1, WD_ON);
        sb_push(50, 51, 3'b111, 1'b0, 1'b1, WD_ON);
        sb_push(52, 53, 3'b111, 1'b1, 1'b0, WD_ON);
        run_to(40);
        u_if.pll_locked = 1'b1;
        run_to(53);
        sb_drained();

        // Reset clears the sticky flag (checked inside do_reset).
        scen = "wdog_clr";
        do_reset(1'b1);
        run_to(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
